// File: rtl/he_lb_csr_pkg.sv
// Host-exerciser loopback CSR map: offsets, FSM states and the decode/read-mux
// helpers shared by the MMIO responder.
package he_lb_csr_pkg;

   localparam logic [11:0] DFH          = 12'h000;
   localparam logic [11:0] ID_L         = 12'h008;
   localparam logic [11:0] ID_H         = 12'h010;
   localparam logic [11:0] SCRATCHPAD0  = 12'h100;
   localparam logic [11:0] SCRATCHPAD1  = 12'h104;
   localparam logic [11:0] SCRATCHPAD2  = 12'h108;
   localparam logic [11:0] DSM_BASEL    = 12'h110;
   localparam logic [11:0] DSM_BASEH    = 12'h114;
   localparam logic [11:0] SRC_ADDR     = 12'h120;
   localparam logic [11:0] DST_ADDR     = 12'h128;
   localparam logic [11:0] NUM_LINES    = 12'h130;
   localparam logic [11:0] CTL          = 12'h138;
   localparam logic [11:0] CFG          = 12'h140;
   localparam logic [11:0] INACT_THRESH = 12'h148;
   localparam logic [11:0] INTERRUPT0   = 12'h150;
   localparam logic [11:0] SWTEST_MSG   = 12'h158;
   localparam logic [11:0] STATUS0      = 12'h160;
   localparam logic [11:0] STATUS1      = 12'h168;
   localparam logic [11:0] ERROR        = 12'h170;
   localparam logic [11:0] STRIDE       = 12'h178;

   localparam int unsigned CTL_RST_N_BIT = 0;
   localparam int unsigned CTL_START_BIT = 1;
   localparam int unsigned CTL_STOP_BIT  = 2;

   typedef enum logic [1:0] {IDLE, RD_DEC, RD_RSP} state_t;

   typedef logic [8:0] qidx_t;

   // Every register seen as a 64-bit qword; 32-bit registers are paired.
   typedef struct packed {
      logic [63:0] dfh;
      logic [63:0] id_l;
      logic [63:0] id_h;
      logic [63:0] scratch01;
      logic [63:0] scratch2;
      logic [63:0] dsm;
      logic [63:0] src;
      logic [63:0] dst;
      logic [63:0] num;
      logic [63:0] ctl;
      logic [63:0] cfg;
      logic [63:0] inact;
      logic [63:0] intr;
      logic [63:0] swtest;
      logic [63:0] status0;
      logic [63:0] status1;
      logic [63:0] err;
      logic [63:0] stride;
   } csr_view_t;

   // Misaligned (non-dword) addresses are treated as outside the window.
   function automatic logic claimed(input logic [19:0] addr);
      return (addr[19:12] == 8'h00) && (addr[1:0] == 2'b00);
   endfunction

   function automatic logic [63:0] rd_qword(input qidx_t q, input csr_view_t v);
      logic [63:0] d;
      d = '0;
      case (q)
         DFH[11:3]:          d = v.dfh;
         ID_L[11:3]:         d = v.id_l;
         ID_H[11:3]:         d = v.id_h;
         SCRATCHPAD0[11:3]:  d = v.scratch01;
         SCRATCHPAD2[11:3]:  d = v.scratch2;
         DSM_BASEL[11:3]:    d = v.dsm;
         SRC_ADDR[11:3]:     d = v.src;
         DST_ADDR[11:3]:     d = v.dst;
         NUM_LINES[11:3]:    d = v.num;
         CTL[11:3]:          d = v.ctl;
         CFG[11:3]:          d = v.cfg;
         INACT_THRESH[11:3]: d = v.inact;
         INTERRUPT0[11:3]:   d = v.intr;
         SWTEST_MSG[11:3]:   d = v.swtest;
         STATUS0[11:3]:      d = v.status0;
         STATUS1[11:3]:      d = v.status1;
         ERROR[11:3]:        d = v.err;
         STRIDE[11:3]:       d = v.stride;
         default:            d = '0;
      endcase
      return d;
   endfunction

   function automatic logic [63:0] rd_data(input qidx_t q, input logic dw, input logic hi,
                                           input csr_view_t v);
      logic [63:0] w;
      logic [31:0] h;
      w = rd_qword(q, v);
      h = hi ? w[63:32] : w[31:0];
      return dw ? {h, h} : w;
   endfunction

   function automatic logic [63:0] wr_mask(input logic dw, input logic hi);
      if (!dw) return '1;
      return hi ? {32'hFFFF_FFFF, 32'h0} : {32'h0, 32'hFFFF_FFFF};
   endfunction

   function automatic logic [63:0] wr_align(input logic dw, input logic [63:0] wdata);
      return dw ? {wdata[31:0], wdata[31:0]} : wdata;
   endfunction

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nv,
                                         input logic [63:0] mask);
      return (old & ~mask) | (nv & mask);
   endfunction

   function automatic logic wr_locked(input qidx_t q);
      return (q == SRC_ADDR[11:3]) || (q == DST_ADDR[11:3]) || (q == NUM_LINES[11:3]) ||
             (q == CFG[11:3]) || (q == STRIDE[11:3]);
   endfunction

endpackage

// File: rtl/he_lb_csr_resp.sv
// MMIO responder for the he_lb CSR map: register writes commit on acceptance,
// reads return registered data with tag echo two cycles after acceptance.
module he_lb_csr_resp
   import he_lb_csr_pkg::*;
#(
   parameter logic [63:0] DFH_VALUE  = 64'h1000_0000_0000_0000,
   parameter logic [63:0] ID_L_VALUE = 64'h0,
   parameter logic [63:0] ID_H_VALUE = 64'h0,
   parameter int unsigned TAG_W      = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mmio_req_valid,
   output logic             mmio_req_ready,
   input  logic             mmio_req_write,
   input  logic             mmio_req_dw,
   input  logic [19:0]      mmio_req_addr,
   input  logic [63:0]      mmio_req_wdata,
   input  logic [TAG_W-1:0] mmio_req_tag,
   output logic             mmio_rsp_valid,
   input  logic             mmio_rsp_ready,
   output logic [63:0]      mmio_rsp_data,
   output logic [TAG_W-1:0] mmio_rsp_tag,
   input  logic             eng_busy,
   input  logic [63:0]      eng_status0,
   input  logic [63:0]      eng_status1,
   input  logic [63:0]      eng_err_set,
   output logic [63:0]      cfg_src_addr,
   output logic [63:0]      cfg_dst_addr,
   output logic [63:0]      cfg_num_lines,
   output logic [63:0]      cfg_cfg,
   output logic [63:0]      cfg_inact_thresh,
   output logic [63:0]      cfg_interrupt0,
   output logic [63:0]      cfg_swtest_msg,
   output logic [63:0]      cfg_stride,
   output logic [63:0]      cfg_dsm_base,
   output logic             eng_rst_n,
   output logic             eng_start,
   output logic             eng_stop
);

   logic [31:0] sp0, sp1, sp2, dsm_l, dsm_h;
   logic [63:0] src, dst, num, cfg, inact, intr, swtest, stride, err;
   logic        ctl_rst_n;

   state_t           state;
   logic [19:0]      rd_addr;
   logic             rd_dw;
   logic [TAG_W-1:0] rd_tag;

   logic        accept, wr_en, wr_ok, lo_en, hi_en;
   qidx_t       wq;
   logic [63:0] wmask, wval, err_clr;
   csr_view_t   view;

   always_comb begin
      accept  = mmio_req_valid && mmio_req_ready;
      wr_en   = accept && mmio_req_write && claimed(mmio_req_addr);
      wq      = mmio_req_addr[11:3];
      wmask   = wr_mask(mmio_req_dw, mmio_req_addr[2]);
      wval    = wr_align(mmio_req_dw, mmio_req_wdata);
      lo_en   = wmask[0];
      hi_en   = wmask[32];
      wr_ok   = wr_en && !(eng_busy && wr_locked(wq));
      err_clr = (wr_en && wq == ERROR[11:3]) ? (wval & wmask) : '0;
   end

   always_comb begin
      view           = '0;
      view.dfh       = DFH_VALUE;
      view.id_l      = ID_L_VALUE;
      view.id_h      = ID_H_VALUE;
      view.scratch01 = {sp1, sp0};
      view.scratch2  = {32'h0, sp2};
      view.dsm       = {dsm_h, dsm_l};
      view.src       = src;
      view.dst       = dst;
      view.num       = num;
      view.ctl       = {63'h0, ctl_rst_n};
      view.cfg       = cfg;
      view.inact     = inact;
      view.intr      = intr;
      view.swtest    = swtest;
      view.status0   = eng_status0;
      view.status1   = eng_status1;
      view.err       = err;
      view.stride    = stride;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp0       <= '0;
         sp1       <= '0;
         sp2       <= '0;
         dsm_l     <= '0;
         dsm_h     <= '0;
         src       <= '0;
         dst       <= '0;
         num       <= '0;
         cfg       <= '0;
         inact     <= '0;
         intr      <= '0;
         swtest    <= '0;
         stride    <= '0;
         err       <= '0;
         ctl_rst_n <= 1'b0;
         eng_start <= 1'b0;
         eng_stop  <= 1'b0;
      end else begin
         eng_start <= 1'b0;
         eng_stop  <= 1'b0;
         // Set strobes are applied after the clear so set wins on the same bit.
         err       <= (err & ~err_clr) | eng_err_set;
         if (wr_ok) begin
            case (wq)
               SCRATCHPAD0[11:3]: begin
                  if (lo_en) sp0 <= wval[31:0];
                  if (hi_en) sp1 <= wval[63:32];
               end
               SCRATCHPAD2[11:3]: if (lo_en) sp2 <= wval[31:0];
               DSM_BASEL[11:3]: begin
                  if (lo_en) dsm_l <= wval[31:0];
                  if (hi_en) dsm_h <= wval[63:32];
               end
               SRC_ADDR[11:3]:     src    <= merge(src, wval, wmask);
               DST_ADDR[11:3]:     dst    <= merge(dst, wval, wmask);
               NUM_LINES[11:3]:    num    <= merge(num, wval, wmask);
               CFG[11:3]:          cfg    <= merge(cfg, wval, wmask);
               INACT_THRESH[11:3]: inact  <= merge(inact, wval, wmask);
               INTERRUPT0[11:3]:   intr   <= merge(intr, wval, wmask);
               SWTEST_MSG[11:3]:   swtest <= merge(swtest, wval, wmask);
               STRIDE[11:3]:       stride <= merge(stride, wval, wmask);
               CTL[11:3]: begin
                  if (lo_en) begin
                     ctl_rst_n <= wval[CTL_RST_N_BIT];
                     eng_start <= wval[CTL_START_BIT];
                     eng_stop  <= wval[CTL_STOP_BIT];
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         mmio_req_ready <= 1'b0;
         mmio_rsp_valid <= 1'b0;
         mmio_rsp_data  <= '0;
         mmio_rsp_tag   <= '0;
         rd_addr        <= '0;
         rd_dw          <= 1'b0;
         rd_tag         <= '0;
      end else begin
         case (state)
            IDLE: begin
               mmio_req_ready <= 1'b1;
               if (accept && !mmio_req_write) begin
                  rd_addr        <= mmio_req_addr;
                  rd_dw          <= mmio_req_dw;
                  rd_tag         <= mmio_req_tag;
                  mmio_req_ready <= 1'b0;
                  state          <= RD_DEC;
               end
            end
            RD_DEC: begin
               mmio_rsp_data  <= claimed(rd_addr) ? rd_data(rd_addr[11:3], rd_dw, rd_addr[2], view) : '0;
               mmio_rsp_tag   <= rd_tag;
               mmio_rsp_valid <= 1'b1;
               state          <= RD_RSP;
            end
            RD_RSP: begin
               if (mmio_rsp_ready) begin
                  mmio_rsp_valid <= 1'b0;
                  mmio_req_ready <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: begin
               mmio_rsp_valid <= 1'b0;
               mmio_req_ready <= 1'b0;
               state          <= IDLE;
            end
         endcase
      end
   end

   assign cfg_src_addr     = src;
   assign cfg_dst_addr     = dst;
   assign cfg_num_lines    = num;
   assign cfg_cfg          = cfg;
   assign cfg_inact_thresh = inact;
   assign cfg_interrupt0   = intr;
   assign cfg_swtest_msg   = swtest;
   assign cfg_stride       = stride;
   assign cfg_dsm_base     = {dsm_h, dsm_l};
   assign eng_rst_n        = ctl_rst_n;

endmodule

// File: tb/tb_he_lb_csr_resp.sv
// Bench for he_lb_csr_resp: vector table of writes/reads plus hand sequences
// for write lock, CTL pulses, sticky ERROR, response stall and mid-read reset.
module tb_he_lb_csr_resp;

   localparam logic [63:0] DFH_V = 64'h1000_0000_0000_0000;
   localparam logic [63:0] STAT0 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] STAT1 = 64'hFEDC_BA98_7654_3210;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mmio_req_valid = 1'b0;
   logic        mmio_req_ready;
   logic        mmio_req_write = 1'b0;
   logic        mmio_req_dw = 1'b0;
   logic [19:0] mmio_req_addr = '0;
   logic [63:0] mmio_req_wdata = '0;
   logic [9:0]  mmio_req_tag = '0;
   logic        mmio_rsp_valid;
   logic        mmio_rsp_ready = 1'b1;
   logic [63:0] mmio_rsp_data;
   logic [9:0]  mmio_rsp_tag;
   logic        eng_busy = 1'b0;
   logic [63:0] eng_status0 = STAT0;
   logic [63:0] eng_status1 = STAT1;
   logic [63:0] eng_err_set = '0;
   logic [63:0] cfg_src_addr, cfg_dst_addr, cfg_num_lines, cfg_cfg, cfg_inact_thresh;
   logic [63:0] cfg_interrupt0, cfg_swtest_msg, cfg_stride, cfg_dsm_base;
   logic        eng_rst_n, eng_start, eng_stop;

   he_lb_csr_resp #(
      .DFH_VALUE (DFH_V),
      .ID_L_VALUE(64'h0),
      .ID_H_VALUE(64'h0),
      .TAG_W     (10)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .mmio_req_valid(mmio_req_valid), .mmio_req_ready(mmio_req_ready),
      .mmio_req_write(mmio_req_write), .mmio_req_dw(mmio_req_dw),
      .mmio_req_addr(mmio_req_addr), .mmio_req_wdata(mmio_req_wdata),
      .mmio_req_tag(mmio_req_tag),
      .mmio_rsp_valid(mmio_rsp_valid), .mmio_rsp_ready(mmio_rsp_ready),
      .mmio_rsp_data(mmio_rsp_data), .mmio_rsp_tag(mmio_rsp_tag),
      .eng_busy(eng_busy), .eng_status0(eng_status0), .eng_status1(eng_status1),
      .eng_err_set(eng_err_set),
      .cfg_src_addr(cfg_src_addr), .cfg_dst_addr(cfg_dst_addr),
      .cfg_num_lines(cfg_num_lines), .cfg_cfg(cfg_cfg),
      .cfg_inact_thresh(cfg_inact_thresh), .cfg_interrupt0(cfg_interrupt0),
      .cfg_swtest_msg(cfg_swtest_msg), .cfg_stride(cfg_stride),
      .cfg_dsm_base(cfg_dsm_base),
      .eng_rst_n(eng_rst_n), .eng_start(eng_start), .eng_stop(eng_stop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] data;
      logic [9:0]  tag;
      string       name;
   } sb_t;

   typedef struct {
      logic        wr;
      logic        dw;
      logic [19:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp;
   } vec_t;

   sb_t  sb[$];
   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail = 0;
   logic [9:0] tag_ctr = 10'h2A5;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Outputs are sampled on the falling edge; a response is consumed at the next rising edge.
   always @(negedge clk) begin
      sb_t e;
      if (rst_n && mmio_rsp_valid && mmio_rsp_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got data %h tag %h, required no response",
                     mmio_rsp_data, mmio_rsp_tag);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_data"}, mmio_rsp_data, e.data);
            chk({e.name, "_tag"}, 64'(mmio_rsp_tag), 64'(e.tag));
         end
      end
   end

   task automatic wait_ready(input string name, output logic ok);
      int w;
      w = 0;
      @(negedge clk);
      while (!mmio_req_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      ok = mmio_req_ready;
      if (!ok) chk({name, "_req_ready_timeout"}, 64'(mmio_req_ready), 64'd1);
   endtask

   task automatic do_write(input logic dw, input logic [19:0] addr, input logic [63:0] wdata,
                           input logic [63:0] err_pulse);
      logic ok;
      wait_ready($sformatf("wr_%h", addr), ok);
      if (!ok) return;
      mmio_req_valid = 1'b1;
      mmio_req_write = 1'b1;
      mmio_req_dw    = dw;
      mmio_req_addr  = addr;
      mmio_req_wdata = wdata;
      eng_err_set    = err_pulse;
      @(posedge clk);
      #1;
      mmio_req_valid = 1'b0;
      mmio_req_write = 1'b0;
      eng_err_set    = '0;
   endtask

   // Returns on the falling edge where the response is first visible.
   task automatic do_read(input logic dw, input logic [19:0] addr, input logic [63:0] exp,
                          input string name, output logic [9:0] tag_used);
      logic ok;
      int   k;
      tag_used = tag_ctr;
      tag_ctr  = tag_ctr + 10'h13;
      wait_ready(name, ok);
      if (!ok) return;
      mmio_req_valid = 1'b1;
      mmio_req_write = 1'b0;
      mmio_req_dw    = dw;
      mmio_req_addr  = addr;
      mmio_req_tag   = tag_used;
      sb.push_back('{exp, tag_used, name});
      @(posedge clk);
      #1;
      mmio_req_valid = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!mmio_rsp_valid && k < 10);
      // Accepted in cycle 0, RD_DEC in cycle 1, response visible in cycle 2.
      chk({name, "_latency"}, 64'(k), 64'd2);
      if (!mmio_rsp_valid) sb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] t;

      tbl.push_back('{1'b1, 1'b0, 20'h00100, 64'hDEAD_BEEF_0123_4567, 64'h0});
      tbl.push_back('{1'b0, 1'b1, 20'h00104, 64'h0, 64'hDEADBEEF_DEADBEEF});
      tbl.push_back('{1'b0, 1'b1, 20'h00100, 64'h0, 64'h01234567_01234567});
      tbl.push_back('{1'b0, 1'b0, 20'h00100, 64'h0, 64'hDEADBEEF_01234567});
      tbl.push_back('{1'b1, 1'b1, 20'h00108, 64'hFFFFFFFF_CAFEF00D, 64'h0});
      tbl.push_back('{1'b0, 1'b1, 20'h00108, 64'h0, 64'hCAFEF00D_CAFEF00D});
      tbl.push_back('{1'b1, 1'b0, 20'h00110, 64'h11112222_33334444, 64'h0});
      tbl.push_back('{1'b0, 1'b1, 20'h00114, 64'h0, 64'h11112222_11112222});
      tbl.push_back('{1'b1, 1'b0, 20'h00120, 64'hA5A5A5A5_5A5A5A5A, 64'h0});
      tbl.push_back('{1'b1, 1'b1, 20'h00124, 64'h00000000_12345678, 64'h0});
      tbl.push_back('{1'b0, 1'b0, 20'h00120, 64'h0, 64'h12345678_5A5A5A5A});
      tbl.push_back('{1'b1, 1'b0, 20'h00000, 64'h5, 64'h0});
      tbl.push_back('{1'b0, 1'b0, 20'h00000, 64'h0, DFH_V});
      tbl.push_back('{1'b1, 1'b0, 20'h01120, 64'hBAD, 64'h0});
      tbl.push_back('{1'b0, 1'b0, 20'h00120, 64'h0, 64'h12345678_5A5A5A5A});
      tbl.push_back('{1'b0, 1'b0, 20'h01000, 64'h0, 64'h0});
      tbl.push_back('{1'b0, 1'b1, 20'h0010C, 64'h0, 64'h0});
      tbl.push_back('{1'b0, 1'b0, 20'h00180, 64'h0, 64'h0});
      tbl.push_back('{1'b1, 1'b1, 20'h0014C, 64'h77, 64'h0});
      tbl.push_back('{1'b0, 1'b0, 20'h00148, 64'h0, 64'h00000077_00000000});
      tbl.push_back('{1'b0, 1'b0, 20'h00160, 64'h0, STAT0});
      tbl.push_back('{1'b0, 1'b1, 20'h0016C, 64'h0, 64'hFEDCBA98_FEDCBA98});
      tbl.push_back('{1'b1, 1'b0, 20'h00160, 64'hFFFF, 64'h0});
      tbl.push_back('{1'b0, 1'b0, 20'h00160, 64'h0, STAT0});
      tbl.push_back('{1'b0, 1'b0, 20'h00008, 64'h0, 64'h0});
      tbl.push_back('{1'b0, 1'b0, 20'h00010, 64'h0, 64'h0});
      tbl.push_back('{1'b1, 1'b0, 20'h00128, 64'h2828, 64'h0});
      tbl.push_back('{1'b1, 1'b0, 20'h00140, 64'h4040, 64'h0});
      tbl.push_back('{1'b1, 1'b0, 20'h00150, 64'h5050, 64'h0});
      tbl.push_back('{1'b1, 1'b0, 20'h00158, 64'h5858, 64'h0});
      tbl.push_back('{1'b1, 1'b0, 20'h00178, 64'h7878, 64'h0});
      tbl.push_back('{1'b0, 1'b0, 20'h00178, 64'h0, 64'h7878});

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 64'(mmio_req_ready), 64'd0);
      chk("rst_rsp_valid", 64'(mmio_rsp_valid), 64'd0);
      chk("rst_eng_rst_n", 64'(eng_rst_n), 64'd0);
      chk("rst_num_lines", cfg_num_lines, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 64'(mmio_req_ready), 64'd1);

      do_read(1'b0, 20'h00000, DFH_V, "rd_dfh", t);
      do_read(1'b0, 20'h00138, 64'h0, "rd_ctl_rst", t);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].wr) do_write(tbl[i].dw, tbl[i].addr, tbl[i].wdata, 64'h0);
         else do_read(tbl[i].dw, tbl[i].addr, tbl[i].exp, $sformatf("vec%0d", i), t);
      end
      chk("cfg_src", cfg_src_addr, 64'h12345678_5A5A5A5A);
      chk("cfg_dsm", cfg_dsm_base, 64'h11112222_33334444);
      chk("cfg_inact", cfg_inact_thresh, 64'h00000077_00000000);
      chk("cfg_dst", cfg_dst_addr, 64'h2828);
      chk("cfg_cfg", cfg_cfg, 64'h4040);
      chk("cfg_swtest", cfg_swtest_msg, 64'h5858);

      // Write lock while engine busy
      do_write(1'b0, 20'h00130, 64'd64, 64'h0);
      chk("num_lines_64", cfg_num_lines, 64'd64);
      eng_busy = 1'b1;
      do_write(1'b0, 20'h00130, 64'd128, 64'h0);
      chk("num_lines_locked", cfg_num_lines, 64'd64);
      do_write(1'b0, 20'h00178, 64'h9, 64'h0);
      chk("stride_locked", cfg_stride, 64'h7878);
      do_write(1'b1, 20'h00108, 64'h55, 64'h0);
      do_write(1'b0, 20'h00150, 64'h1234, 64'h0);
      chk("intr_unlocked", cfg_interrupt0, 64'h1234);
      do_read(1'b1, 20'h00108, 64'h00000055_00000055, "sp2_busy", t);
      eng_busy = 1'b0;
      do_write(1'b0, 20'h00130, 64'd128, 64'h0);
      chk("num_lines_128", cfg_num_lines, 64'd128);

      // CTL start/stop pulses
      do_write(1'b0, 20'h00138, 64'h3, 64'h0);
      chk("start_pulse", 64'(eng_start), 64'd1);
      chk("stop_quiet", 64'(eng_stop), 64'd0);
      chk("eng_rst_n_set", 64'(eng_rst_n), 64'd1);
      @(posedge clk); #1;
      chk("start_end", 64'(eng_start), 64'd0);
      do_read(1'b0, 20'h00138, 64'h1, "rd_ctl", t);
      do_write(1'b0, 20'h00138, 64'h5, 64'h0);
      chk("stop_pulse", 64'(eng_stop), 64'd1);
      chk("start_quiet", 64'(eng_start), 64'd0);
      @(posedge clk); #1;
      chk("stop_end", 64'(eng_stop), 64'd0);

      // Sticky ERROR
      @(negedge clk);
      eng_err_set = 64'h10;
      @(posedge clk); #1;
      eng_err_set = '0;
      do_read(1'b0, 20'h00170, 64'h10, "err_set", t);
      do_write(1'b0, 20'h00170, 64'h10, 64'h0);
      do_read(1'b0, 20'h00170, 64'h0, "err_clr", t);
      do_write(1'b0, 20'h00170, 64'h4, 64'h4);
      do_read(1'b0, 20'h00170, 64'h4, "err_set_wins", t);
      do_write(1'b0, 20'h00170, 64'h4, 64'h0);
      do_read(1'b0, 20'h00170, 64'h0, "err_clr2", t);

      // Response stall: data/tag held, status change after RD_DEC not visible
      @(posedge clk); #1;
      mmio_rsp_ready = 1'b0;
      do_read(1'b0, 20'h00160, STAT0, "stall", t);
      eng_status0 = 64'h0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("stall%0d_valid", i), 64'(mmio_rsp_valid), 64'd1);
         chk($sformatf("stall%0d_data", i), mmio_rsp_data, STAT0);
         chk($sformatf("stall%0d_tag", i), 64'(mmio_rsp_tag), 64'(t));
         chk($sformatf("stall%0d_req_ready", i), 64'(mmio_req_ready), 64'd0);
      end
      @(posedge clk); #1;
      mmio_rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_done_valid", 64'(mmio_rsp_valid), 64'd0);
      chk("stall_done_ready", 64'(mmio_req_ready), 64'd1);
      eng_status0 = STAT0;

      // Reset in RD_RSP discards the response
      mmio_rsp_ready = 1'b0;
      do_read(1'b0, 20'h00000, DFH_V, "rst_rd", t);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 64'(mmio_rsp_valid), 64'd0);
      chk("midrst_req_ready", 64'(mmio_req_ready), 64'd0);
      chk("midrst_eng_rst_n", 64'(eng_rst_n), 64'd0);
      sb.delete();
      mmio_rsp_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst%0d_valid", i), 64'(mmio_rsp_valid), 64'd0);
      end
      chk("post_rst_ready", 64'(mmio_req_ready), 64'd1);
      do_read(1'b0, 20'h00100, 64'h0, "post_rst_sp", t);
      do_read(1'b0, 20'h00000, DFH_V, "post_rst_dfh", t);

      repeat (4) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
